// File: rtl/subleq_sequencer_pkg.sv
// Shared definitions for the SUBLEQ core: word width, reserved addresses,
// instruction length and the sequencer state encoding.
package subleq_sequencer_pkg;

    localparam int unsigned REG_WIDTH   = 8;
    localparam int unsigned INSTR_WORDS = 3;

    typedef logic [REG_WIDTH-1:0] reg_t;

    localparam reg_t START_ADDR = '0;
    localparam reg_t HALT_ADDR  = '1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH_A,
        FETCH_B,
        FETCH_C,
        LOAD_A,
        LOAD_B,
        WRITE,
        HALT
    } seq_state_t;

endpackage

// File: rtl/subleq.sv
// SUBLEQ ALU: result = reg_2 - reg_1 computed as a (REG_WIDTH+1)-bit signed
// difference; branch when that difference is <= 0.
// Ports:
//   reg_1  - subtrahend (mem[A])
//   reg_2  - minuend (mem[B])
//   result - low REG_WIDTH bits of the difference
//   branch - difference is zero or negative
module subleq
    import subleq_sequencer_pkg::*;
(
    input  logic [REG_WIDTH-1:0] reg_1,
    input  logic [REG_WIDTH-1:0] reg_2,
    output logic [REG_WIDTH-1:0] result,
    output logic                 branch
);

    // One extra bit keeps 0-(-128) positive and -128-1 negative.
    logic signed [REG_WIDTH:0] diff;

    assign diff   = $signed({reg_2[REG_WIDTH-1], reg_2}) - $signed({reg_1[REG_WIDTH-1], reg_1});
    assign result = diff[REG_WIDTH-1:0];
    assign branch = diff[REG_WIDTH] || (diff == '0);

endmodule

// File: rtl/subleq_sequencer.sv
// SUBLEQ control unit: fetches A, B, C, loads mem[A] and mem[B], writes
// mem[B] - mem[A] back to mem[B] and steers the PC. Six cycles per
// instruction against a synchronous single-port memory (read data one cycle
// after the address).
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   start       - pulse, honoured in IDLE or HALT
//   mem_addr    - memory address (registered)
//   mem_we      - write strobe, only in WRITE
//   mem_wdata   - write data, ALU result in WRITE, else 0
//   mem_rdata   - memory read data
//   busy        - executing instructions
//   halted      - in HALT
//   retire      - one pulse per WRITE cycle
//   pc          - address of the current instruction
module subleq_sequencer
    import subleq_sequencer_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic [REG_WIDTH-1:0] mem_addr,
    output logic                 mem_we,
    output logic [REG_WIDTH-1:0] mem_wdata,
    input  logic [REG_WIDTH-1:0] mem_rdata,
    output logic                 busy,
    output logic                 halted,
    output logic                 retire,
    output logic [REG_WIDTH-1:0] pc
);

    seq_state_t state;
    reg_t       addr_a;
    reg_t       addr_b;
    reg_t       target_c;
    reg_t       op_a;
    reg_t       alu_result;
    logic       alu_branch;
    reg_t       pc_plus1;
    reg_t       pc_plus2;
    reg_t       pc_next_seq;

    // PC incrementers wrap modulo 2^REG_WIDTH.
    assign pc_plus1    = pc + REG_WIDTH'(1);
    assign pc_plus2    = pc + REG_WIDTH'(2);
    assign pc_next_seq = pc + REG_WIDTH'(INSTR_WORDS);

    // mem[B] arrives on mem_rdata during WRITE (address B was presented in LOAD_B).
    subleq u_alu (
        .reg_1  (op_a),
        .reg_2  (mem_rdata),
        .result (alu_result),
        .branch (alu_branch)
    );

    // Write strobe is gated by reset so a reset landing in WRITE suppresses the store.
    assign mem_we    = (state == WRITE) && !reset;
    assign mem_wdata = (state == WRITE) ? alu_result : '0;

    // Sequencer: mem_addr is loaded with the address the next state presents.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            pc       <= START_ADDR;
            mem_addr <= '0;
            busy     <= 1'b0;
            halted   <= 1'b0;
            retire   <= 1'b0;
            addr_a   <= '0;
            addr_b   <= '0;
            target_c <= '0;
            op_a     <= '0;
        end else begin
            retire <= 1'b0;
            case (state)
                IDLE, HALT: begin
                    if (start) begin
                        state    <= FETCH_A;
                        pc       <= START_ADDR;
                        mem_addr <= START_ADDR;
                        busy     <= 1'b1;
                        halted   <= 1'b0;
                    end
                end
                FETCH_A: begin
                    state    <= FETCH_B;
                    mem_addr <= pc_plus1;
                end
                FETCH_B: begin
                    addr_a   <= mem_rdata;
                    state    <= FETCH_C;
                    mem_addr <= pc_plus2;
                end
                FETCH_C: begin
                    addr_b   <= mem_rdata;
                    state    <= LOAD_A;
                    mem_addr <= addr_a;
                end
                LOAD_A: begin
                    target_c <= mem_rdata;
                    state    <= LOAD_B;
                    mem_addr <= addr_b;
                end
                LOAD_B: begin
                    op_a     <= mem_rdata;
                    state    <= WRITE;
                    mem_addr <= addr_b;
                    retire   <= 1'b1;
                end
                WRITE: begin
                    if (alu_branch) begin
                        pc       <= target_c;
                        mem_addr <= target_c;
                        if (target_c == HALT_ADDR) begin
                            state  <= HALT;
                            busy   <= 1'b0;
                            halted <= 1'b1;
                        end else begin
                            state <= FETCH_A;
                        end
                    end else begin
                        pc       <= pc_next_seq;
                        mem_addr <= pc_next_seq;
                        state    <= FETCH_A;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
